mips_multicycle_core: RTL

Multicycle MIPS core that runs the datapath over several clock cycles under a control FSM. It replaces the single-cycle datapath with one shared ALU and a single unified memory port that uses a request/ready handshake, so memory may insert wait states. It keeps the register debug read port and adds a retired-instruction counter and an illegal-opcode trap. The core sits between the top-level wrapper and a shared instruction/data memory.

---
 rtl/mips_multicycle_core.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS core: one shared ALU and one unified memory port with a
// request/ready handshake, plus a retired-instruction counter and illegal trap.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 Reset,
    output logic                 MemReq,
    output logic                 MemWE,
    output logic [31:0]          MemAddr,
    output logic [31:0]          MemWData,
    input  logic [31:0]          MemRData,
    input  logic                 MemReady,
    output logic [31:0]          PC,
    input  logic [4:0]           ReadReg,
    output logic [31:0]          RegData,
    output logic [CNT_WIDTH-1:0] RetiredCount,
    output logic                 Illegal
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP, S_ILLEGAL
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 r_state;
    logic [31:0]            r_pc, r_ir, r_mdr, r_a, r_b, r_aluout;
    logic [31:0]            r_rf [32];
    logic [CNT_WIDTH-1:0]   r_retired;
    logic                   r_illegal;

    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [31:0] w_imm_sx, w_imm_zx, w_alu_a, w_alu_b, w_alu_y;
    logic [2:0]  w_alu_ctl, w_funct_ctl;
    logic        w_funct_ok, w_zero;

    function automatic logic [31:0] alu(input logic [2:0] ctl, input logic [31:0] x, input logic [31:0] y);
        case (ctl)
            ALU_AND: alu = x & y;
            ALU_OR:  alu = x | y;
            ALU_ADD: alu = x + y;
            ALU_SUB: alu = x - y;
            ALU_SLT: alu = {31'd0, ($signed(x) < $signed(y))};
            default: alu = x + y;
        endcase
    endfunction

    assign w_op     = r_ir[31:26];
    assign w_rs     = r_ir[25:21];
    assign w_rt     = r_ir[20:16];
    assign w_rd     = r_ir[15:11];
    assign w_funct  = r_ir[5:0];
    assign w_imm_sx = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_imm_zx = {16'd0, r_ir[15:0]};
    assign w_alu_y  = alu(w_alu_ctl, w_alu_a, w_alu_b);
    assign w_zero   = (w_alu_y == 32'd0);

    // Memory port is a pure decode of state and registers, never of MemReady.
    assign MemReq       = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign MemWE        = (r_state == S_MEMWR);
    assign MemAddr      = ((r_state == S_MEMRD) || (r_state == S_MEMWR)) ? r_aluout : r_pc;
    assign MemWData     = r_b;
    assign PC           = r_pc;
    assign RetiredCount = r_retired;
    assign Illegal      = r_illegal;
    assign RegData      = (ReadReg == 5'd0) ? 32'd0 : r_rf[ReadReg];

    // R-type funct to ALU control, flagging unsupported functs.
    always_comb begin
        w_funct_ok  = 1'b1;
        w_funct_ctl = ALU_ADD;
        case (w_funct)
            6'b100000: w_funct_ctl = ALU_ADD;
            6'b100010: w_funct_ctl = ALU_SUB;
            6'b100100: w_funct_ctl = ALU_AND;
            6'b100101: w_funct_ctl = ALU_OR;
            6'b101010: w_funct_ctl = ALU_SLT;
            default:   w_funct_ok  = 1'b0;
        endcase
    end

    // Operand and operation select for the single shared ALU.
    always_comb begin
        w_alu_ctl = ALU_ADD;
        w_alu_a   = r_pc;
        w_alu_b   = 32'd4;
        case (r_state)
            S_FETCH: begin
                w_alu_a = r_pc;
                w_alu_b = 32'd4;
            end
            S_DECODE: begin
                w_alu_a = r_pc;
                w_alu_b = {w_imm_sx[29:0], 2'b00};
            end
            S_MEMADR: begin
                w_alu_a = r_a;
                w_alu_b = w_imm_sx;
            end
            S_EXEC: begin
                w_alu_ctl = w_funct_ctl;
                w_alu_a   = r_a;
                w_alu_b   = r_b;
            end
            S_IEXEC: begin
                w_alu_a = r_a;
                if (w_op == OP_ORI) begin
                    w_alu_ctl = ALU_OR;
                    w_alu_b   = w_imm_zx;
                end else begin
                    w_alu_ctl = ALU_ADD;
                    w_alu_b   = w_imm_sx;
                end
            end
            S_BRANCH: begin
                w_alu_ctl = ALU_SUB;
                w_alu_a   = r_a;
                w_alu_b   = r_b;
            end
            default: begin
                w_alu_ctl = ALU_ADD;
                w_alu_a   = r_pc;
                w_alu_b   = 32'd4;
            end
        endcase
    end

    // Control FSM together with all architectural state.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_ir      <= 32'd0;
            r_mdr     <= 32'd0;
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_aluout  <= 32'd0;
            r_retired <= {CNT_WIDTH{1'b0}};
            r_illegal <= 1'b0;
            for (int i = 0; i < 32; i++) r_rf[i] <= 32'd0;
        end else begin
            case (r_state)
                S_FETCH: if (MemReady) begin
                    r_ir    <= MemRData;
                    r_pc    <= w_alu_y;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_a      <= r_rf[w_rs];
                    r_b      <= r_rf[w_rt];
                    r_aluout <= w_alu_y;
                    case (w_op)
                        OP_LW, OP_SW:   r_state <= S_MEMADR;
                        OP_ADDI, OP_ORI: r_state <= S_IEXEC;
                        OP_BEQ:         r_state <= S_BRANCH;
                        OP_J:           r_state <= S_JUMP;
                        OP_RTYPE: begin
                            r_state   <= w_funct_ok ? S_EXEC : S_ILLEGAL;
                            r_illegal <= ~w_funct_ok;
                        end
                        default: begin
                            r_state   <= S_ILLEGAL;
                            r_illegal <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR: begin
                    r_aluout <= w_alu_y;
                    r_state  <= (w_op == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: if (MemReady) begin
                    r_mdr   <= MemRData;
                    r_state <= S_MEMWB;
                end
                S_MEMWB: begin
                    if (w_rt != 5'd0) r_rf[w_rt] <= r_mdr;
                    r_retired <= r_retired + CNT_ONE;
                    r_state   <= S_FETCH;
                end
                S_MEMWR: if (MemReady) begin
                    r_retired <= r_retired + CNT_ONE;
                    r_state   <= S_FETCH;
                end
                S_EXEC: begin
                    r_aluout <= w_alu_y;
                    r_state  <= S_ALUWB;
                end
                S_ALUWB: begin
                    if (w_rd != 5'd0) r_rf[w_rd] <= r_aluout;
                    r_retired <= r_retired + CNT_ONE;
                    r_state   <= S_FETCH;
                end
                S_IEXEC: begin
                    r_aluout <= w_alu_y;
                    r_state  <= S_IWB;
                end
                S_IWB: begin
                    if (w_rt != 5'd0) r_rf[w_rt] <= r_aluout;
                    r_retired <= r_retired + CNT_ONE;
                    r_state   <= S_FETCH;
                end
                S_BRANCH: begin
                    if (w_zero) r_pc <= r_aluout;
                    r_retired <= r_retired + CNT_ONE;
                    r_state   <= S_FETCH;
                end
                S_JUMP: begin
                    r_pc      <= {r_pc[31:28], r_ir[25:0], 2'b00};
                    r_retired <= r_retired + CNT_ONE;
                    r_state   <= S_FETCH;
                end
                S_ILLEGAL: r_state <= S_ILLEGAL;
                default:   r_state <= S_FETCH;
            endcase
        end
    end

endmodule
